data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/mem_pkg.sv | 24 ++
 rtl/data_mem_responder_if.sv | 25 ++
 rtl/load_store_align.sv | 57 +++++
 rtl/data_mem_responder.sv | 123 ++++++++++++
 tb/tb_data_mem_responder.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the data memory responder: funct3 size codes,
// FSM state encoding and the latched request record.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

endpackage

// File: rtl/data_mem_responder_if.sv
// Processor-side load/store request and response channels of the responder.
interface data_mem_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_f3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_f3, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_f3, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/load_store_align.sv
// Combinational lane steering: byte enables, store-data replication,
// load extraction with sign/zero extension, and size/alignment error detection.
module load_store_align
    import mem_pkg::*;
(
    input  logic [2:0]  f3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] mem_word,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_lanes,
    output logic [31:0] rdata_ext,
    output logic        fmt_err
);

    logic [7:0]  lane [4];
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane[gi] = mem_word[8*gi +: 8];
        end
    endgenerate

    assign rd_byte = lane[addr_lo];
    assign rd_half = {lane[{addr_lo[1], 1'b1}], lane[{addr_lo[1], 1'b0}]};

    always_comb begin
        byte_en     = 4'b0000;
        wdata_lanes = 32'h0;
        rdata_ext   = 32'h0;
        fmt_err     = 1'b0;
        case (f3)
            F3_B, F3_BU: begin
                byte_en     = 4'b0001 << addr_lo;
                wdata_lanes = {4{wdata[7:0]}};
                rdata_ext   = (f3 == F3_B) ? {{24{rd_byte[7]}}, rd_byte} : {24'h0, rd_byte};
            end
            F3_H, F3_HU: begin
                fmt_err     = addr_lo[0];
                byte_en     = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_lanes = {2{wdata[15:0]}};
                rdata_ext   = (f3 == F3_H) ? {{16{rd_half[15]}}, rd_half} : {16'h0, rd_half};
            end
            F3_W: begin
                fmt_err     = (addr_lo != 2'b00);
                byte_en     = 4'b1111;
                wdata_lanes = wdata;
                rdata_ext   = mem_word;
            end
            default: fmt_err = 1'b1;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding load/store responder over a byte-enabled word memory,
// with a fixed programmable wait between request acceptance and response.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input logic                 clk,
    input logic                 reset,
    data_mem_responder_if.slave bus
);

    localparam int         AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    state_t      state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;
    req_t        req_reg;
    logic        resp_valid_reg;
    logic [31:0] resp_rdata_reg;
    logic        resp_err_reg;

    logic [3:0][7:0] mem [DEPTH_WORDS];

    req_t        live_req, cur_req;
    logic        accept, enter_resp, mem_we;
    logic        range_err, fmt_err, req_err;
    logic [3:0]  byte_en;
    logic [31:0] wdata_lanes, rdata_ext, mem_word;
    logic [AW-1:0] word_idx;

    assign live_req = '{we: bus.req_we, f3: bus.req_f3, addr: bus.req_addr, wdata: bus.req_wdata};
    // With no wait the memory is accessed on the accepting edge itself, before req_reg is loaded
    assign cur_req  = (state_reg == ST_IDLE) ? live_req : req_reg;

    assign accept    = (state_reg == ST_IDLE) && bus.req_valid;
    assign word_idx  = cur_req.addr[AW+1:2];
    assign range_err = ({2'b00, cur_req.addr[31:2]} >= $unsigned(DEPTH_WORDS));
    assign req_err   = range_err | fmt_err;
    assign mem_word  = mem[word_idx];
    assign mem_we    = enter_resp & cur_req.we & ~req_err & reset;

    load_store_align u_align (
        .f3          (cur_req.f3),
        .addr_lo     (cur_req.addr[1:0]),
        .wdata       (cur_req.wdata),
        .mem_word    (mem_word),
        .byte_en     (byte_en),
        .wdata_lanes (wdata_lanes),
        .rdata_ext   (rdata_ext),
        .fmt_err     (fmt_err)
    );

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        enter_resp = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    cnt_next = WAIT_LOAD;
                    if (WAIT_LOAD != 4'd0) begin
                        state_next = ST_WAIT;
                    end else begin
                        state_next = ST_RESP;
                        enter_resp = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                cnt_next = cnt_reg - 4'd1;
                if (cnt_reg == 4'd1) begin
                    state_next = ST_RESP;
                    enter_resp = 1'b1;
                end
            end
            ST_RESP: begin
                if (bus.resp_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= 4'd0;
            req_reg        <= '0;
            resp_valid_reg <= 1'b0;
            resp_rdata_reg <= 32'h0;
            resp_err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) req_reg <= live_req;
            if (enter_resp) begin
                resp_valid_reg <= 1'b1;
                resp_err_reg   <= req_err;
                resp_rdata_reg <= (req_err || cur_req.we) ? 32'h0 : rdata_ext;
            end else if (state_reg == ST_RESP && bus.resp_ready) begin
                resp_valid_reg <= 1'b0;
                resp_err_reg   <= 1'b0;
                resp_rdata_reg <= 32'h0;
            end
        end
    end

    // Memory contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) mem[word_idx][i] <= wdata_lanes[8*i +: 8];
            end
        end
    end

    assign bus.req_ready  = (state_reg == ST_IDLE) & reset;
    assign bus.resp_valid = resp_valid_reg;
    assign bus.resp_rdata = resp_rdata_reg;
    assign bus.resp_err   = resp_err_reg;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized load/store bench for data_mem_responder against a byte-level
// memory model, plus directed reset, back-pressure and zero-wait cases.
module tb_data_mem_responder;
    localparam int DEPTH = 256;
    localparam int WAITC = 2;

    logic clk;
    logic reset;

    data_mem_responder_if bus ();
    data_mem_responder_if bus0 ();

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vec_count  = 0;
    int miss_count = 0;
    int txn_count  = 0;
    bit [31:0] ref_mem [DEPTH];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_count++;
        if (got !== exp) begin
            miss_count++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Reference: size/sign from funct3, natural alignment, range, little-endian bytes
    task automatic model(input bit we, input bit [2:0] f3, input bit [31:0] addr,
                         input bit [31:0] wdata, output bit [31:0] rd, output bit err);
        int size;
        bit sgn;
        int idx;
        int off;
        rd = '0; err = 1'b0; size = 1; sgn = 1'b0;
        case (f3)
            3'd0: begin size = 1; sgn = 1'b1; end
            3'd1: begin size = 2; sgn = 1'b1; end
            3'd2: size = 4;
            3'd4: size = 1;
            3'd5: size = 2;
            default: err = 1'b1;
        endcase
        if (addr % size != 0) err = 1'b1;
        if (addr / 4 >= DEPTH) err = 1'b1;
        if (err) return;
        idx = int'(addr / 4);
        off = int'(addr % 4);
        for (int k = 0; k < size; k++) begin
            if (we) ref_mem[idx][8*(off+k) +: 8] = wdata[8*k +: 8];
            else    rd[8*k +: 8] = ref_mem[idx][8*(off+k) +: 8];
        end
        if (!we && sgn && rd[8*size-1]) rd = rd | (32'hFFFF_FFFF << (8*size));
    endtask

    task automatic drive_req(input bit we, input bit [2:0] f3, input bit [31:0] addr, input bit [31:0] wdata);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_f3    = f3;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
    endtask

    task automatic wait_accept();
        int n = 0;
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("accept_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic scramble();
        bus.req_valid = 1'b0;
        bus.req_we    = 1'($urandom_range(0, 1));
        bus.req_f3    = 3'($urandom_range(0, 7));
        bus.req_addr  = $urandom;
        bus.req_wdata = $urandom;
    endtask

    // Called #1 after the accepting edge; ends #1 after the handshake edge
    task automatic collect(input bit we, input bit [2:0] f3, input bit [31:0] addr, input bit [31:0] wdata,
                           input int stall, output bit [31:0] rd, output bit er);
        bit [31:0] exp_rd;
        bit exp_err;
        int lat = 0;
        model(we, f3, addr, wdata, exp_rd, exp_err);
        while (!bus.resp_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq("resp_valid", 32'(bus.resp_valid), 32'd1);
        check_eq("latency", 32'(lat), 32'(WAITC));
        check_eq("rdata", bus.resp_rdata, exp_rd);
        check_eq("err", 32'(bus.resp_err), 32'(exp_err));
        rd = bus.resp_rdata;
        er = bus.resp_err;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check_eq("hold_valid", 32'(bus.resp_valid), 32'd1);
            check_eq("hold_rdata", bus.resp_rdata, exp_rd);
            check_eq("hold_err", 32'(bus.resp_err), 32'(exp_err));
            check_eq("hold_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
        check_eq("clr_valid", 32'(bus.resp_valid), 32'd0);
        check_eq("clr_rdata", bus.resp_rdata, 32'd0);
        check_eq("clr_err", 32'(bus.resp_err), 32'd0);
        txn_count++;
        $display("txn %0d: we=%0b f3=%0d addr=%08h wdata=%08h -> rdata=%08h err=%0b lat=%0d",
                 txn_count, we, f3, addr, wdata, rd, er, lat);
    endtask

    task automatic run_req(input bit we, input bit [2:0] f3, input bit [31:0] addr, input bit [31:0] wdata,
                           input int stall, output bit [31:0] rd, output bit er);
        drive_req(we, f3, addr, wdata);
        wait_accept();
        scramble();
        collect(we, f3, addr, wdata, stall, rd, er);
    endtask

    initial begin
        bit [31:0] rd;
        bit er;
        bit [31:0] saved;
        bit [31:0] a;

        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_f3 = 3'd0;
        bus.req_addr = '0; bus.req_wdata = '0; bus.resp_ready = 1'b0;
        bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_f3 = 3'd0;
        bus0.req_addr = '0; bus0.req_wdata = '0; bus0.resp_ready = 1'b0;
        reset = 1'b0;

        repeat (3) @(negedge clk);
        check_eq("rst_ready", 32'(bus.req_ready), 32'd0);
        check_eq("rst_valid", 32'(bus.resp_valid), 32'd0);
        check_eq("rst_rdata", bus.resp_rdata, 32'd0);
        check_eq("rst_err", 32'(bus.resp_err), 32'd0);
        reset = 1'b1;
        #1;
        check_eq("rel_ready", 32'(bus.req_ready), 32'd1);
        check_eq("rel_ready0", 32'(bus0.req_ready), 32'd1);

        for (int w = 0; w < DEPTH; w++) run_req(1'b1, 3'd2, 32'(w * 4), $urandom, 0, rd, er);

        // SW then LW at 0x10
        run_req(1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF, 0, rd, er);
        check_eq("sw10_err", 32'(er), 32'd0);
        run_req(1'b0, 3'd2, 32'h10, 32'h0, 0, rd, er);
        check_eq("lw10", rd, 32'hDEAD_BEEF);

        // byte store into a known word, then word/byte loads
        run_req(1'b1, 3'd2, 32'h10, 32'h1122_3344, 0, rd, er);
        run_req(1'b1, 3'd0, 32'h13, 32'h1234_5680, 1, rd, er);
        run_req(1'b0, 3'd2, 32'h10, 32'h0, 0, rd, er);
        check_eq("lw10_sb", rd, 32'h8022_3344);
        run_req(1'b0, 3'd0, 32'h13, 32'h0, 0, rd, er);
        check_eq("lb13", rd, 32'hFFFF_FF80);
        run_req(1'b0, 3'd4, 32'h13, 32'h0, 0, rd, er);
        check_eq("lbu13", rd, 32'h0000_0080);

        // error cases
        run_req(1'b0, 3'd1, 32'h11, 32'h0, 0, rd, er);
        check_eq("lh11_err", 32'(er), 32'd1);
        check_eq("lh11_rdata", rd, 32'd0);
        saved = ref_mem[0];
        run_req(1'b1, 3'd2, 32'h400, 32'h5555_AAAA, 0, rd, er);
        check_eq("sw400_err", 32'(er), 32'd1);
        run_req(1'b0, 3'd2, 32'h0, 32'h0, 0, rd, er);
        check_eq("word0_kept", rd, saved);
        run_req(1'b0, 3'd3, 32'h8, 32'h0, 0, rd, er);
        check_eq("f3_011_err", 32'(er), 32'd1);

        // back-pressure with the next request already waiting
        drive_req(1'b0, 3'd2, 32'h10, 32'h0);
        wait_accept();
        drive_req(1'b0, 3'd0, 32'h13, 32'h0);
        collect(1'b0, 3'd2, 32'h10, 32'h0, 5, rd, er);
        check_eq("bp_idle_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1;
        check_eq("bp_next_accepted", 32'(bus.req_ready), 32'd0);
        scramble();
        collect(1'b0, 3'd0, 32'h13, 32'h0, 0, rd, er);
        check_eq("bp_lb13", rd, 32'hFFFF_FF80);

        // reset during WAIT aborts the store
        saved = ref_mem[8];
        drive_req(1'b1, 3'd2, 32'h20, 32'hCAFE_F00D);
        wait_accept();
        scramble();
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("rstw_valid", 32'(bus.resp_valid), 32'd0);
        check_eq("rstw_rdata", bus.resp_rdata, 32'd0);
        check_eq("rstw_ready", 32'(bus.req_ready), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        check_eq("rstw_rel_ready", 32'(bus.req_ready), 32'd1);
        run_req(1'b0, 3'd2, 32'h20, 32'h0, 0, rd, er);
        check_eq("rstw_word_kept", rd, saved);

        // reset while a response is pending clears outputs without a clock edge
        drive_req(1'b0, 3'd5, 32'h12, 32'h0);
        wait_accept();
        scramble();
        repeat (WAITC) begin
            @(posedge clk);
            #1;
        end
        check_eq("rstr_pre_valid", 32'(bus.resp_valid), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("rstr_valid", 32'(bus.resp_valid), 32'd0);
        check_eq("rstr_rdata", bus.resp_rdata, 32'd0);
        check_eq("rstr_err", 32'(bus.resp_err), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;

        for (int t = 0; t < 300; t++) begin
            if ($urandom_range(0, 9) == 0) a = $urandom_range(0, 32'h3FFF);
            else                           a = $urandom_range(0, 1023);
            run_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
                    int'($urandom_range(0, 3)), rd, er);
        end

        // zero-wait instance: response right after the accepting edge
        @(negedge clk);
        bus0.req_valid = 1'b1; bus0.req_we = 1'b1; bus0.req_f3 = 3'd2;
        bus0.req_addr = 32'h8; bus0.req_wdata = 32'h1234_5678;
        check_eq("w0_ready", 32'(bus0.req_ready), 32'd1);
        @(posedge clk);
        #1;
        bus0.req_valid = 1'b0;
        check_eq("w0_sw_valid", 32'(bus0.resp_valid), 32'd1);
        bus0.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus0.resp_ready = 1'b0;
        check_eq("w0_sw_clr", 32'(bus0.resp_valid), 32'd0);
        bus0.req_valid = 1'b1; bus0.req_we = 1'b0;
        @(posedge clk);
        #1;
        bus0.req_valid = 1'b0;
        check_eq("w0_lw_valid", 32'(bus0.resp_valid), 32'd1);
        check_eq("w0_lw_rdata", bus0.resp_rdata, 32'h1234_5678);
        bus0.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus0.resp_ready = 1'b0;
        $display("txn w0: we=0 f3=2 addr=00000008 -> rdata=%08h", 32'h1234_5678);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
